// File: rtl/note_player_if.sv
// note_player_if: note request handshake (val/rdy plus note fields) between a melody sequencer and the player.
// With NOTE_PLAYER_DUTY_EN defined the bus also carries a separate high-phase length.
interface note_player_if #(parameter int PW = 8, parameter int CW = 8);
    logic          val;
    logic          rdy;
    logic [PW-1:0] period;
    logic [CW-1:0] cycles;
`ifdef NOTE_PLAYER_DUTY_EN
    logic [PW-1:0] high;
    modport master(output val, period, high, cycles, input rdy);
    modport slave(input val, period, high, cycles, output rdy);
`else
    modport master(output val, period, cycles, input rdy);
    modport slave(input val, period, cycles, output rdy);
`endif
endinterface

// File: rtl/note_player_seq.sv
// note_player_seq: plays a square wave for N full periods per accepted note, then pulses done.
// NOTE_PLAYER_DUTY_EN selects a separate high-phase length; otherwise the high phase equals the low phase.
module note_player_seq #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    note_player_if.slave      bus,
    input  logic              stop,
    output logic              note,
    output logic              done,
    output logic [5:0]        state
);
    typedef enum logic [5:0] {
        IDLE      = 6'b000000,
        LOAD_HIGH = 6'b100000,
        WAIT_HIGH = 6'b010000,
        LOAD_LOW  = 6'b001000,
        WAIT_LOW  = 6'b000100,
        DONE      = 6'b000010
    } state_t;
    state_t        st, nxt;
    logic [PW-1:0] p, h, cnt;
    logic [CW-1:0] rem;
    logic          empty;
`ifdef NOTE_PLAYER_DUTY_EN
    logic [PW-1:0] hl;
    assign h     = hl;
    assign empty = bus.period == '0 || bus.cycles == '0 || bus.high == '0;
`else
    assign h     = p;
    assign empty = bus.period == '0 || bus.cycles == '0;
`endif
    assign bus.rdy = st == IDLE;
    assign note    = st == LOAD_HIGH || st == WAIT_HIGH;
    assign done    = st == DONE;
    assign state   = st;
    always_comb begin
        nxt = IDLE;
        case (st)
            IDLE:      nxt = bus.val ? (empty ? DONE : LOAD_HIGH) : IDLE;
            LOAD_HIGH: nxt = stop ? DONE : WAIT_HIGH;
            WAIT_HIGH: nxt = stop ? DONE : cnt == PW'(1) ? LOAD_LOW : WAIT_HIGH;
            LOAD_LOW:  nxt = stop ? DONE : WAIT_LOW;
            WAIT_LOW:  nxt = stop ? DONE : cnt != PW'(1) ? WAIT_LOW : rem == CW'(1) ? DONE : LOAD_HIGH;
            default:   nxt = IDLE; // DONE and any non-one-hot encoding
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            st  <= IDLE;
            p   <= '0;
            cnt <= '0;
            rem <= '0;
`ifdef NOTE_PLAYER_DUTY_EN
            hl  <= '0;
`endif
        end else begin
            st <= nxt;
            case (st)
                IDLE: if (bus.val) begin
                    p   <= bus.period;
                    rem <= bus.cycles;
`ifdef NOTE_PLAYER_DUTY_EN
                    hl  <= bus.high;
`endif
                end
                LOAD_HIGH: cnt <= h;
                WAIT_HIGH: cnt <= cnt - PW'(1);
                LOAD_LOW:  cnt <= p;
                WAIT_LOW: begin
                    cnt <= cnt - PW'(1);
                    if (cnt == PW'(1)) rem <= rem - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_note_player_seq.sv
// tb_note_player_seq: directed vectors with hand-computed waveforms for note_player_seq (PW=8, CW=8).
module tb_note_player_seq;
    logic       clk = 0, rst = 0, stop = 0;
    logic       note, done;
    logic [5:0] state;
    int         vectors = 0, errs = 0;
    logic [63:0] np, dp;
    int         highs, done_at;
    note_player_if #(.PW(8), .CW(8)) bus();
    note_player_seq #(.PW(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stop(stop),
        .note(note), .done(done), .state(state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic reset();
        rst = 0;
        step();
        rst = 1;
    endtask
    // Leaves the bench at the sample point of cycle 1 after the accept edge.
    task automatic send(input logic [7:0] p, input logic [7:0] n, input logic [7:0] h);
        bus.val    = 1;
        bus.period = p;
        bus.cycles = n;
`ifdef NOTE_PLAYER_DUTY_EN
        bus.high   = h;
`else
        if (h != h) bus.val = 0;
`endif
        step();
        bus.val = 0;
    endtask
    task automatic play(input logic [7:0] p, input logic [7:0] n, input logic [7:0] h,
                        input int ncyc, input int junk,
                        output logic [63:0] nv, output logic [63:0] dv);
        nv = '0;
        dv = '0;
        send(p, n, h);
        for (int k = 1; k <= ncyc; k++) begin
            nv[k-1] = note;
            dv[k-1] = done;
            bus.val = k <= junk;
            if (k <= junk) bus.period = 8'd7;
            if (k < ncyc) step();
        end
        bus.val = 0;
    endtask
    task automatic count(input logic [7:0] p, input logic [7:0] n, output int hi, output int at);
        hi = 0;
        at = 0;
        send(p, n, p);
        for (int k = 1; k <= 1100; k++) begin
            hi += int'(note);
            if (done) begin
                at = k;
                break;
            end
            step();
        end
    endtask
    initial begin
        bus.val = 0;
        bus.period = 0;
        bus.cycles = 0;
`ifdef NOTE_PLAYER_DUTY_EN
        bus.high = 0;
`endif
        step();
        step();
        chk("rst_state", state, 6'b000000);
        chk("rst_note", note, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", bus.rdy, 1);
        rst = 1;
        play(8'd2, 8'd1, 8'd2, 7, 0, np, dp);
        chk("p2n1_note", np, 64'h07);
        chk("p2n1_done", dp, 64'h40);
        chk("p2n1_st7", state, 6'b000010);
        step();
        chk("p2n1_st8", state, 6'b000000);
        chk("p2n1_rdy8", bus.rdy, 1);
        reset();
        play(8'd1, 8'd3, 8'd1, 14, 0, np, dp);
        chk("p1n3_note", np, 64'h333);
        chk("p1n3_done", dp, 64'h1000);
        reset();
        send(8'd0, 8'd5, 8'd1);
        chk("p0_state", state, 6'b000010);
        chk("p0_note", note, 0);
        step();
        chk("p0_idle", state, 6'b000000);
        reset();
        send(8'd4, 8'd0, 8'd4);
        chk("n0_state", state, 6'b000010);
        chk("n0_note", note, 0);
        step();
        chk("n0_idle", state, 6'b000000);
        reset();
        play(8'd3, 8'd2, 8'd3, 18, 5, np, dp);
        chk("busy_val_note", np, 64'h0F0F);
        chk("busy_val_done", dp, 64'h10000);
        reset();
        play(8'd3, 8'd2, 8'd3, 2, 0, np, dp);
        chk("midrst_wh", state, 6'b010000);
        rst = 0;
        step();
        rst = 1;
        chk("midrst_state", state, 6'b000000);
        chk("midrst_note", note, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rdy", bus.rdy, 1);
        play(8'd2, 8'd4, 8'd2, 5, 0, np, dp);
        chk("stop_wl", state, 6'b000100);
        stop = 1;
        step();
        stop = 0;
        chk("stop_state", state, 6'b000010);
        chk("stop_note", note, 0);
        chk("stop_done", done, 1);
        step();
        chk("stop_idle", state, 6'b000000);
        play(8'd2, 8'd4, 8'd2, 2, 0, np, dp);
        stop = 1;
        rst = 0;
        step();
        stop = 0;
        rst = 1;
        chk("stoprst_state", state, 6'b000000);
        chk("stoprst_done", done, 0);
        step();
        chk("stoprst_done2", done, 0);
        count(8'd255, 8'd1, highs, done_at);
        chk("maxp_high", highs, 256);
        chk("maxp_done_at", done_at, 513);
        reset();
        count(8'd1, 8'd255, highs, done_at);
        chk("maxn_high", highs, 510);
        chk("maxn_done_at", done_at, 1021);
        reset();
`ifdef NOTE_PLAYER_DUTY_EN
        play(8'd3, 8'd2, 8'd1, 13, 0, np, dp);
        chk("duty_note", np, 64'hC3);
        chk("duty_done", dp, 64'h1000);
        reset();
        send(8'd3, 8'd2, 8'd0);
        chk("duty_h0", state, 6'b000010);
        reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
